ddr_arbiter: RTL and testbench

Round-robin arbiter that shares the single DDR3 Avalon-MM port (DDRAM_*) among several burst-capable requesters: ROM download writes, frame buffer writes and ROM/tile reads. Sits in the clk_sys domain between the client masters and the emu-level DDRAM pins. Grants are locked for the full duration of one burst. Read data is routed back only to the owning requester.

---
 rtl/ddr_arbiter.sv | 179 +++++++++++++++++
 tb/tb_ddr_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_arbiter.sv
// ddr_arbiter: round-robin owner of the shared DDR3 Avalon-MM port.
// A grant is held for one whole burst; read beats go back only to the owner.
module ddr_arbiter #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 32,
    parameter int BURST_W   = 8
) (
    input  logic                         clk_sys,
    input  logic                         reset_sys_n,
    input  logic [NUM_PORTS-1:0]         req_rd,
    input  logic [NUM_PORTS-1:0]         req_wr,
    input  logic [NUM_PORTS*ADDR_W-1:0]  req_addr,
    input  logic [NUM_PORTS*BURST_W-1:0] req_burst,
    input  logic [NUM_PORTS*64-1:0]      req_din,
    input  logic [NUM_PORTS*8-1:0]       req_be,
    output logic [NUM_PORTS-1:0]         req_wait,
    output logic [NUM_PORTS-1:0]         req_valid,
    output logic [63:0]                  req_dout,
    output logic                         ddr_rd,
    output logic                         ddr_wr,
    output logic [ADDR_W-4:0]            ddr_addr,
    output logic [BURST_W-1:0]           ddr_burst,
    output logic [63:0]                  ddr_din,
    output logic [7:0]                   ddr_be,
    input  logic                         ddr_busy,
    input  logic                         ddr_valid,
    input  logic [63:0]                  ddr_dout
);
    localparam int OWN_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_READ_CMD  = 2'd1,
        ST_READ_DATA = 2'd2,
        ST_WRITE     = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [OWN_W-1:0]     r_owner, w_owner_nxt;
    logic [OWN_W-1:0]     r_next, w_next_nxt;
    logic [BURST_W-1:0]   r_cnt, w_cnt_nxt;

    logic [NUM_PORTS-1:0] w_cand;
    logic                 w_found;
    logic [OWN_W-1:0]     w_win;
    logic                 w_win_rd;
    logic [BURST_W-1:0]   w_win_burst;
    logic [ADDR_W-4:0]    w_own_waddr;
    logic [BURST_W-1:0]   w_own_burst;
    logic [63:0]          w_own_din;
    logic [7:0]           w_own_be;
    logic                 w_last;
    logic                 w_cmd;
    logic                 w_unused_addr_lsb;

    // Port index base+k wrapped into 0..NUM_PORTS-1.
    function automatic logic [OWN_W-1:0] rr_add(input logic [OWN_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_PORTS) s = s - NUM_PORTS;
        return OWN_W'(s);
    endfunction

    assign w_cand   = req_rd | req_wr;
    assign w_cmd    = (r_state == ST_READ_CMD) || (r_state == ST_WRITE);
    assign w_last   = (r_cnt <= BURST_W'(1));
    assign req_dout = ddr_dout;

    // Pick the first requesting port at or after the rotation pointer.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!w_found && w_cand[rr_add(r_next, k)]) begin
                w_found = 1'b1;
                w_win   = rr_add(r_next, k);
            end
        end
    end

    // Select the winner's request fields and the current owner's bus fields.
    always_comb begin
        w_win_rd          = 1'b0;
        w_win_burst       = '0;
        w_own_waddr       = '0;
        w_own_burst       = '0;
        w_own_din         = '0;
        w_own_be          = '0;
        w_unused_addr_lsb = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_unused_addr_lsb = w_unused_addr_lsb ^ (^req_addr[i*ADDR_W +: 3]);
            if (w_win == OWN_W'(i)) begin
                w_win_rd    = req_rd[i];
                w_win_burst = req_burst[i*BURST_W +: BURST_W];
            end
            if (r_owner == OWN_W'(i)) begin
                w_own_waddr = req_addr[i*ADDR_W+3 +: ADDR_W-3];
                w_own_burst = req_burst[i*BURST_W +: BURST_W];
                w_own_din   = req_din[i*64 +: 64];
                w_own_be    = req_be[i*8 +: 8];
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, then count beats until the burst ends.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_next_nxt  = r_next;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_owner_nxt = w_win;
                    w_next_nxt  = rr_add(w_win, 1);
                    w_cnt_nxt   = (w_win_burst == '0) ? BURST_W'(1) : w_win_burst;
                    w_state_nxt = w_win_rd ? ST_READ_CMD : ST_WRITE;
                end
            end
            ST_READ_CMD: begin
                if (!ddr_busy) w_state_nxt = ST_READ_DATA;
            end
            ST_READ_DATA: begin
                if (ddr_valid) begin
                    w_cnt_nxt = r_cnt - BURST_W'(1);
                    if (w_last) w_state_nxt = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (!ddr_busy) begin
                    w_cnt_nxt = r_cnt - BURST_W'(1);
                    if (w_last) w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Drive the DDR command bus and per-port handshakes from the owner.
    always_comb begin
        ddr_rd    = (r_state == ST_READ_CMD);
        ddr_wr    = (r_state == ST_WRITE);
        ddr_addr  = '0;
        ddr_burst = '0;
        ddr_din   = '0;
        ddr_be    = '0;
        req_wait  = '1;
        req_valid = '0;
        if (w_cmd) begin
            ddr_addr  = w_own_waddr;
            ddr_burst = w_own_burst;
        end
        if (r_state == ST_WRITE) begin
            ddr_din = w_own_din;
            ddr_be  = w_own_be;
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_owner == OWN_W'(i)) begin
                if (w_cmd) req_wait[i] = ddr_busy;
                if (r_state == ST_READ_DATA) req_valid[i] = ddr_valid;
            end
        end
    end

    // State, owner, rotation pointer and beat counter registers.
    always_ff @(posedge clk_sys or negedge reset_sys_n) begin
        if (!reset_sys_n) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_next  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_next  <= w_next_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end
endmodule

// File: tb/tb_ddr_arbiter.sv
// Directed bench for ddr_arbiter with a transaction-level reference model.
module tb_ddr_arbiter;
    localparam int NP = 3;

    logic          clk_sys = 1'b0;
    logic          reset_sys_n;
    logic [NP-1:0] req_rd, req_wr;
    logic [NP*32-1:0] req_addr;
    logic [NP*8-1:0]  req_burst;
    logic [NP*64-1:0] req_din;
    logic [NP*8-1:0]  req_be;
    logic [NP-1:0] req_wait, req_valid;
    logic [63:0]   req_dout;
    logic          ddr_rd, ddr_wr;
    logic [28:0]   ddr_addr;
    logic [7:0]    ddr_burst;
    logic [63:0]   ddr_din;
    logic [7:0]    ddr_be;
    logic          ddr_busy, ddr_valid;
    logic [63:0]   ddr_dout;

    int n_checks = 0;
    int n_pass   = 0;

    ddr_arbiter #(.NUM_PORTS(NP), .ADDR_W(32), .BURST_W(8)) dut (
        .clk_sys(clk_sys), .reset_sys_n(reset_sys_n),
        .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
        .req_burst(req_burst), .req_din(req_din), .req_be(req_be),
        .req_wait(req_wait), .req_valid(req_valid), .req_dout(req_dout),
        .ddr_rd(ddr_rd), .ddr_wr(ddr_wr), .ddr_addr(ddr_addr),
        .ddr_burst(ddr_burst), .ddr_din(ddr_din), .ddr_be(ddr_be),
        .ddr_busy(ddr_busy), .ddr_valid(ddr_valid), .ddr_dout(ddr_dout)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Returns the number of edges until a DDR command shows up, 0 on timeout.
    task automatic wait_cmd(output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk_sys);
            #2;
            if (ddr_rd || ddr_wr) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic set_port(input int p, input logic [31:0] a, input logic [7:0] b,
                            input logic [63:0] d, input logic [7:0] e);
        req_addr[p*32 +: 32] = a;
        req_burst[p*8 +: 8]  = b;
        req_din[p*64 +: 64]  = d;
        req_be[p*8 +: 8]     = e;
    endtask

    // Reference model: one active transaction {port, read?, command taken?, beats left}
    // plus the rotation pointer. Checked mid-cycle, advanced with the inputs the edge will see.
    bit m_act, m_rd, m_cmd;
    int m_port, m_left, m_ptr;
    initial begin
        logic          e_rd, e_wr;
        logic [31:0]   t_addr;
        logic [28:0]   e_addr;
        logic [7:0]    e_burst, e_be;
        logic [63:0]   e_din;
        logic [NP-1:0] e_wait, e_valid;
        int            b;
        m_act = 0; m_rd = 0; m_cmd = 0; m_port = 0; m_left = 0; m_ptr = 0;
        forever begin
            @(negedge clk_sys);
            if (!reset_sys_n) begin
                m_act = 0; m_rd = 0; m_cmd = 0; m_port = 0; m_left = 0; m_ptr = 0;
            end
            e_rd    = m_act && m_rd && !m_cmd;
            e_wr    = m_act && !m_rd;
            t_addr  = req_addr[m_port*32 +: 32];
            e_addr  = (e_rd || e_wr) ? t_addr[31:3] : 29'd0;
            e_burst = (e_rd || e_wr) ? req_burst[m_port*8 +: 8] : 8'd0;
            e_din   = e_wr ? req_din[m_port*64 +: 64] : 64'd0;
            e_be    = e_wr ? req_be[m_port*8 +: 8] : 8'd0;
            e_wait  = '1;
            e_valid = '0;
            if (e_rd || e_wr) e_wait[m_port] = ddr_busy;
            if (m_act && m_rd && m_cmd) e_valid[m_port] = ddr_valid;
            chk("cyc_ddr_rd", 64'(ddr_rd), 64'(e_rd));
            chk("cyc_ddr_wr", 64'(ddr_wr), 64'(e_wr));
            chk("cyc_ddr_addr", 64'(ddr_addr), 64'(e_addr));
            chk("cyc_ddr_burst", 64'(ddr_burst), 64'(e_burst));
            chk("cyc_ddr_din", ddr_din, e_din);
            chk("cyc_ddr_be", 64'(ddr_be), 64'(e_be));
            chk("cyc_req_wait", 64'(req_wait), 64'(e_wait));
            chk("cyc_req_valid", 64'(req_valid), 64'(e_valid));
            chk("cyc_req_dout", req_dout, ddr_dout);
            if (reset_sys_n) begin
                if (!m_act) begin
                    for (int k = 0; k < NP; k++) begin
                        int p;
                        p = (m_ptr + k) % NP;
                        if (!m_act && (req_rd[p] || req_wr[p])) begin
                            m_act  = 1;
                            m_port = p;
                            m_rd   = req_rd[p];
                            m_cmd  = 0;
                            b      = int'(req_burst[p*8 +: 8]);
                            m_left = (b == 0) ? 1 : b;
                            m_ptr  = (p + 1) % NP;
                        end
                    end
                end else if (m_rd && !m_cmd) begin
                    if (!ddr_busy) m_cmd = 1;
                end else if (m_rd) begin
                    if (ddr_valid) begin
                        m_left--;
                        if (m_left == 0) m_act = 0;
                    end
                end else begin
                    if (!ddr_busy) begin
                        m_left--;
                        if (m_left == 0) m_act = 0;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acc;
        int beat;
        bit busy_tbl [10];
        int order [4];
        int p;
        busy_tbl = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
        order    = '{0, 1, 2, 0};
        reset_sys_n = 1'b0;
        req_rd = '0; req_wr = '0; req_addr = '0; req_burst = '0; req_din = '0; req_be = '0;
        ddr_busy = 1'b0; ddr_valid = 1'b0; ddr_dout = '0;
        repeat (3) tick();
        chk("rst_req_wait", 64'(req_wait), 64'h7);
        chk("rst_ddr_rd", 64'(ddr_rd), 64'h0);
        chk("rst_ddr_addr", 64'(ddr_addr), 64'h0);
        chk("rst_req_valid", 64'(req_valid), 64'h0);
        reset_sys_n = 1'b1;

        // Single read on port 2
        set_port(2, 32'h3000_0040, 8'd4, 64'h0, 8'h0);
        req_rd[2] = 1'b1;
        wait_cmd(n);
        chk("rd_grant_lat", 64'(n), 64'd1);
        chk("rd_ddr_rd", 64'(ddr_rd), 64'h1);
        chk("rd_ddr_addr", 64'(ddr_addr), 64'h0600_0008);
        chk("rd_ddr_burst", 64'(ddr_burst), 64'd4);
        chk("rd_req_wait", 64'(req_wait), 64'h3);
        ddr_valid = 1'b1;
        ddr_dout  = 64'hDEAD;
        #1;
        chk("rd_cmd_valid_drop", 64'(req_valid), 64'h0);
        tick();
        req_rd[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ddr_valid = 1'b1;
            ddr_dout  = 64'hA0 + 64'(i);
            #1;
            chk("rd_beat_valid", 64'(req_valid), 64'h4);
            chk("rd_beat_dout", req_dout, 64'hA0 + 64'(i));
            tick();
        end
        ddr_valid = 1'b0;
        #1;
        chk("rd_done_idle_rd", 64'(ddr_rd), 64'h0);
        chk("rd_done_idle_wait", 64'(req_wait), 64'h7);

        // Contention: three 1-beat writes, port 0 re-requests
        set_port(0, 32'h0000_0100, 8'd1, 64'h1111, 8'hFF);
        set_port(1, 32'h0000_0200, 8'd1, 64'h2222, 8'h0F);
        set_port(2, 32'h0000_0300, 8'd1, 64'h3333, 8'hF0);
        req_wr = 3'b111;
        for (int g = 0; g < 4; g++) begin
            p = order[g];
            wait_cmd(n);
            chk("rr_grant_lat", 64'(n), 64'd1);
            chk("rr_ddr_wr", 64'(ddr_wr), 64'h1);
            chk("rr_owner_wait", 64'(req_wait), 64'(3'b111 & ~(3'b001 << p)));
            chk("rr_ddr_addr", 64'(ddr_addr), 64'(32'h100 * (p + 1)) >> 3);
            tick();
            if (g > 0) req_wr[p] = 1'b0;
            if (g == 3) req_wr[0] = 1'b0;
            #1;
            chk("rr_bubble", 64'(ddr_wr), 64'h0);
        end

        // Backpressured 8-beat write on port 1
        set_port(1, 32'h0000_1000, 8'd8, 64'hD0, 8'hAA);
        req_wr[1] = 1'b1;
        wait_cmd(n);
        chk("bp_grant_lat", 64'(n), 64'd1);
        acc  = 0;
        beat = 0;
        for (int c = 0; c < 10; c++) begin
            ddr_busy = busy_tbl[c];
            req_din[64 +: 64] = 64'hD0 + 64'(beat);
            #1;
            chk("bp_ddr_wr", 64'(ddr_wr), 64'h1);
            chk("bp_req_wait", 64'(req_wait), busy_tbl[c] ? 64'h7 : 64'h5);
            chk("bp_ddr_din", ddr_din, 64'hD0 + 64'(beat));
            if (ddr_wr && !ddr_busy) acc++;
            tick();
            if (!busy_tbl[c]) beat++;
        end
        req_wr[1] = 1'b0;
        ddr_busy  = 1'b0;
        #1;
        chk("bp_end_wr", 64'(ddr_wr), 64'h0);
        chk("bp_beats", 64'(acc), 64'd8);

        // Burst length 0 read on port 0 behaves as one beat
        set_port(0, 32'h0000_0040, 8'd0, 64'h0, 8'h0);
        req_rd[0] = 1'b1;
        wait_cmd(n);
        chk("b0_grant_lat", 64'(n), 64'd1);
        chk("b0_ddr_rd", 64'(ddr_rd), 64'h1);
        chk("b0_ddr_burst", 64'(ddr_burst), 64'h0);
        chk("b0_ddr_addr", 64'(ddr_addr), 64'h8);
        tick();
        req_rd[0] = 1'b0;
        ddr_valid = 1'b1;
        ddr_dout  = 64'h5A5A;
        #1;
        chk("b0_valid", 64'(req_valid), 64'h1);
        tick();
        chk("b0_idle_wait", 64'(req_wait), 64'h7);
        chk("b0_idle_valid_drop", 64'(req_valid), 64'h0);
        ddr_valid = 1'b0;

        // Reset in the middle of a 4-beat read on port 1
        set_port(1, 32'h0000_2000, 8'd4, 64'h0, 8'h0);
        req_rd[1] = 1'b1;
        wait_cmd(n);
        chk("rr_rst_grant", 64'(req_wait), 64'h5);
        tick();
        req_rd[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ddr_valid = 1'b1;
            #1;
            chk("rst_pre_valid", 64'(req_valid), 64'h2);
            tick();
        end
        reset_sys_n = 1'b0;
        #1;
        chk("rst_mid_ddr_rd", 64'(ddr_rd), 64'h0);
        chk("rst_mid_wait", 64'(req_wait), 64'h7);
        chk("rst_mid_valid", 64'(req_valid), 64'h0);
        tick();
        reset_sys_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("rst_post_valid", 64'(req_valid), 64'h0);
            tick();
        end
        ddr_valid = 1'b0;

        // Port 2 with both read and write: read first, write next round
        set_port(2, 32'h0000_5000, 8'd1, 64'h7777, 8'h3C);
        req_rd[2] = 1'b1;
        req_wr[2] = 1'b1;
        wait_cmd(n);
        chk("rw_first_rd", 64'(ddr_rd), 64'h1);
        chk("rw_first_wr", 64'(ddr_wr), 64'h0);
        tick();
        req_rd[2] = 1'b0;
        ddr_valid = 1'b1;
        #1;
        chk("rw_rd_valid", 64'(req_valid), 64'h4);
        tick();
        ddr_valid = 1'b0;
        wait_cmd(n);
        chk("rw_wr_grant_lat", 64'(n), 64'd1);
        chk("rw_second_wr", 64'(ddr_wr), 64'h1);
        chk("rw_wr_wait", 64'(req_wait), 64'h3);
        chk("rw_wr_be", 64'(ddr_be), 64'h3C);
        tick();
        req_wr[2] = 1'b0;
        #1;
        chk("rw_end_wr", 64'(ddr_wr), 64'h0);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
